// File: rtl/heap_pkg.sv
// Shared types for the heap RAM port scheduler.
// Default widths, FSM states and arbiter grant encoding.
package heap_pkg;

    localparam int HEAP_ADDR_W = 30;
    localparam int HEAP_VAL_W  = 63;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WRITE,
        RESP,
        LOAD
    } sched_state_t;

    typedef enum logic {
        REDUCER,
        LOADER
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter between the reducer and the loader.
// Grants are combinational; the last winner is remembered in a register.
module rr_arbiter2
    import heap_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_red,
    input  logic req_ld,
    output logic gnt_red,
    output logic gnt_ld
);

    grant_t last_grant;

    always_comb begin
        gnt_red = en && req_red && (!req_ld || last_grant == LOADER);
        gnt_ld  = en && req_ld && !gnt_red;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= LOADER;
        end else if (gnt_red) begin
            last_grant <= REDUCER;
        end else if (gnt_ld) begin
            last_grant <= LOADER;
        end
    end

endmodule

// File: rtl/heap_port_scheduler.sv
// Heap RAM port scheduler for the SKI reduction core.
// Serialises reducer bundles and loader writes onto a 2R/2W RAM.
module heap_port_scheduler
    import heap_pkg::*;
#(
    parameter int ADDR_W = HEAP_ADDR_W,
    parameter int VAL_W  = HEAP_VAL_W,
    parameter int RD_LAT = 1
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_rd_en_i,
    input  logic [2*ADDR_W-1:0]   req_rd_addr_i,
    input  logic [1:0]            req_wr_en_i,
    input  logic [2*ADDR_W-1:0]   req_wr_addr_i,
    input  logic [2*VAL_W-1:0]    req_wr_data_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    input  logic [VAL_W-1:0]      ld_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [1:0]            rsp_mask_o,
    output logic [2*VAL_W-1:0]    rsp_data_o,
    output logic [1:0]            mem_rd_en_o,
    output logic [2*ADDR_W-1:0]   mem_rd_addr_o,
    input  logic [2*VAL_W-1:0]    mem_rd_data_i,
    output logic [1:0]            mem_wr_en_o,
    output logic [2*ADDR_W-1:0]   mem_wr_addr_o,
    output logic [2*VAL_W-1:0]    mem_wr_data_o,
    output logic                  busy_o
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    sched_state_t        state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [1:0]          rd_en_q, rd_en_n;
    logic [1:0]          wr_en_q, wr_en_n, wr_keep;
    logic [2*ADDR_W-1:0] wr_addr_q, wr_addr_n;
    logic [2*VAL_W-1:0]  wr_data_q, wr_data_n;
    logic [2*VAL_W-1:0]  rsp_data_q, rsp_data_n;
    logic [1:0]          mrd_en_q, mrd_en_n;
    logic [2*ADDR_W-1:0] mrd_addr_q, mrd_addr_n;
    logic [1:0]          mwr_en_q, mwr_en_n;
    logic [2*ADDR_W-1:0] mwr_addr_q, mwr_addr_n;
    logic [2*VAL_W-1:0]  mwr_data_q, mwr_data_n;
    logic                arb_en, gnt_red, gnt_ld;

    assign arb_en = (state == IDLE) && !system1000_rst;

    rr_arbiter2 u_arb (
        .clk     (system1000),
        .rst     (system1000_rst),
        .en      (arb_en),
        .req_red (req_valid_i),
        .req_ld  (ld_valid_i),
        .gnt_red (gnt_red),
        .gnt_ld  (gnt_ld)
    );

    // Equal-address write pair: slot1 carries the surviving value.
    always_comb begin
        wr_keep = wr_en_q;
        if (&wr_en_q &&
            wr_addr_q[2*ADDR_W-1:ADDR_W] == wr_addr_q[ADDR_W-1:0])
            wr_keep[0] = 1'b0;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rd_en_n    = rd_en_q;
        wr_en_n    = wr_en_q;
        wr_addr_n  = wr_addr_q;
        wr_data_n  = wr_data_q;
        rsp_data_n = rsp_data_q;
        mrd_en_n   = '0;
        mrd_addr_n = '0;
        mwr_en_n   = '0;
        mwr_addr_n = '0;
        mwr_data_n = '0;
        unique case (state)
            IDLE: begin
                if (gnt_red) begin
                    state_n    = ISSUE;
                    rd_en_n    = req_rd_en_i;
                    wr_en_n    = req_wr_en_i;
                    wr_addr_n  = req_wr_addr_i;
                    wr_data_n  = req_wr_data_i;
                    mrd_en_n   = req_rd_en_i;
                    mrd_addr_n = req_rd_addr_i &
                                 {{ADDR_W{req_rd_en_i[1]}},
                                  {ADDR_W{req_rd_en_i[0]}}};
                end else if (gnt_ld) begin
                    state_n    = LOAD;
                    mwr_en_n   = 2'b01;
                    mwr_addr_n = {{ADDR_W{1'b0}}, ld_addr_i};
                    mwr_data_n = {{VAL_W{1'b0}}, ld_data_i};
                end
            end
            ISSUE: begin
                // Reads are already on the RAM; writes follow a cycle later.
                state_n    = WRITE;
                cnt_n      = CW'(RD_LAT - 1);
                mwr_en_n   = wr_keep;
                mwr_addr_n = wr_addr_q &
                             {{ADDR_W{wr_keep[1]}}, {ADDR_W{wr_keep[0]}}};
                mwr_data_n = wr_data_q &
                             {{VAL_W{wr_keep[1]}}, {VAL_W{wr_keep[0]}}};
            end
            WRITE: begin
                if (cnt == '0) begin
                    state_n    = RESP;
                    rsp_data_n = mem_rd_data_i &
                                 {{VAL_W{rd_en_q[1]}}, {VAL_W{rd_en_q[0]}}};
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i)
                    state_n = IDLE;
            end
            LOAD: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_en_q    <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rsp_data_q <= '0;
            mrd_en_q   <= '0;
            mrd_addr_q <= '0;
            mwr_en_q   <= '0;
            mwr_addr_q <= '0;
            mwr_data_q <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rd_en_q    <= rd_en_n;
            wr_en_q    <= wr_en_n;
            wr_addr_q  <= wr_addr_n;
            wr_data_q  <= wr_data_n;
            rsp_data_q <= rsp_data_n;
            mrd_en_q   <= mrd_en_n;
            mrd_addr_q <= mrd_addr_n;
            mwr_en_q   <= mwr_en_n;
            mwr_addr_q <= mwr_addr_n;
            mwr_data_q <= mwr_data_n;
        end
    end

    assign req_ready_o   = gnt_red;
    assign ld_ready_o    = gnt_ld;
    assign rsp_valid_o   = (state == RESP);
    assign rsp_mask_o    = rd_en_q;
    assign rsp_data_o    = rsp_data_q;
    assign mem_rd_en_o   = mrd_en_q;
    assign mem_rd_addr_o = mrd_addr_q;
    assign mem_wr_en_o   = mwr_en_q;
    assign mem_wr_addr_o = mwr_addr_q;
    assign mem_wr_data_o = mwr_data_q;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_heap_port_scheduler.sv
// Scoreboard bench for heap_port_scheduler with a reference heap model.
// Second instance built with RD_LAT=3 checks the capture cycle.
module tb_heap_port_scheduler;

    localparam int AW = 30;
    localparam int VW = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            req_valid_i, req_ready_o;
    logic [1:0]      req_rd_en_i, req_wr_en_i;
    logic [2*AW-1:0] req_rd_addr_i, req_wr_addr_i;
    logic [2*VW-1:0] req_wr_data_i;
    logic            ld_valid_i, ld_ready_o;
    logic [AW-1:0]   ld_addr_i;
    logic [VW-1:0]   ld_data_i;
    logic            rsp_valid_o, rsp_ready_i;
    logic [1:0]      rsp_mask_o;
    logic [2*VW-1:0] rsp_data_o;
    logic [1:0]      mem_rd_en_o, mem_wr_en_o;
    logic [2*AW-1:0] mem_rd_addr_o, mem_wr_addr_o;
    logic [2*VW-1:0] mem_rd_data_i, mem_wr_data_o;
    logic            busy_o;

    heap_port_scheduler #(.ADDR_W(AW), .VAL_W(VW), .RD_LAT(1)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_rd_en_i    (req_rd_en_i),
        .req_rd_addr_i  (req_rd_addr_i),
        .req_wr_en_i    (req_wr_en_i),
        .req_wr_addr_i  (req_wr_addr_i),
        .req_wr_data_i  (req_wr_data_i),
        .ld_valid_i     (ld_valid_i),
        .ld_ready_o     (ld_ready_o),
        .ld_addr_i      (ld_addr_i),
        .ld_data_i      (ld_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_mask_o     (rsp_mask_o),
        .rsp_data_o     (rsp_data_o),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .busy_o         (busy_o)
    );

    logic            l3_req_valid, l3_req_ready;
    logic [1:0]      l3_rd_en;
    logic [2*AW-1:0] l3_rd_addr;
    logic            l3_ld_ready, l3_rsp_valid;
    logic [1:0]      l3_rsp_mask, l3_mem_rd_en, l3_mem_wr_en;
    logic [2*VW-1:0] l3_rsp_data, l3_mem_rd_data, l3_mem_wr_data;
    logic [2*AW-1:0] l3_mem_rd_addr, l3_mem_wr_addr;
    logic            l3_busy;
    logic [2:0]      l3_sh = '0;

    heap_port_scheduler #(.ADDR_W(AW), .VAL_W(VW), .RD_LAT(3)) dut_l3 (
        .system1000     (clk),
        .system1000_rst (rst),
        .req_valid_i    (l3_req_valid),
        .req_ready_o    (l3_req_ready),
        .req_rd_en_i    (l3_rd_en),
        .req_rd_addr_i  (l3_rd_addr),
        .req_wr_en_i    (2'b00),
        .req_wr_addr_i  ({2*AW{1'b0}}),
        .req_wr_data_i  ({2*VW{1'b0}}),
        .ld_valid_i     (1'b0),
        .ld_ready_o     (l3_ld_ready),
        .ld_addr_i      ({AW{1'b0}}),
        .ld_data_i      ({VW{1'b0}}),
        .rsp_valid_o    (l3_rsp_valid),
        .rsp_ready_i    (1'b1),
        .rsp_mask_o     (l3_rsp_mask),
        .rsp_data_o     (l3_rsp_data),
        .mem_rd_en_o    (l3_mem_rd_en),
        .mem_rd_addr_o  (l3_mem_rd_addr),
        .mem_rd_data_i  (l3_mem_rd_data),
        .mem_wr_en_o    (l3_mem_wr_en),
        .mem_wr_addr_o  (l3_mem_wr_addr),
        .mem_wr_data_o  (l3_mem_wr_data),
        .busy_o         (l3_busy)
    );

    // RD_LAT=3 RAM: valid data only exactly three cycles after the read.
    always @(posedge clk) l3_sh <= {l3_sh[1:0], |l3_mem_rd_en};
    assign l3_mem_rd_data = l3_sh[2] ? {2{63'hDEAD}} : {2{63'h5A5A}};

    // Main RAM model, one-cycle read latency.
    logic [VW-1:0] ram [16];
    bit clr_mem;
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (mem_wr_en_o[k])
                    ram[mem_wr_addr_o[k*AW +: 4]] <= mem_wr_data_o[k*VW +: VW];
        end
        for (int k = 0; k < 2; k++)
            if (mem_rd_en_o[k])
                mem_rd_data_i[k*VW +: VW] <= ram[mem_rd_addr_o[k*AW +: 4]];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference model: heap contents, pending responses, grant history.
    logic [VW-1:0]     ref_mem [16];
    logic [2*VW+1:0]   exp_q[$];
    bit                grant_log[$];
    int                tb_last;
    bit                exp_r;
    logic [2*VW-1:0]   md;

    always @(negedge clk) begin
        if (clr_mem)
            for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        if (rst) begin
            exp_q.delete();
            tb_last = 1;
        end else begin
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: mask=%b with no bundle pending",
                             rsp_mask_o);
                end else begin
                    check("rsp", {rsp_mask_o, rsp_data_o}, exp_q[0]);
                    if (rsp_ready_i) void'(exp_q.pop_front());
                end
            end
            if (mem_wr_en_o == 2'b11)
                check("wr_pair_distinct",
                      mem_wr_addr_o[2*AW-1:AW] != mem_wr_addr_o[AW-1:0], 1);
            if (req_ready_o || ld_ready_o) begin
                exp_r = req_valid_i && (!ld_valid_i || tb_last == 1);
                check("arb", {req_ready_o, ld_ready_o},
                      {exp_r, ld_valid_i && !exp_r});
                if (req_valid_i && req_ready_o) begin
                    md = '0;
                    for (int k = 0; k < 2; k++)
                        if (req_rd_en_i[k])
                            md[k*VW +: VW] = ref_mem[req_rd_addr_i[k*AW +: 4]];
                    exp_q.push_back({req_rd_en_i, md});
                    for (int k = 0; k < 2; k++)
                        if (req_wr_en_i[k])
                            ref_mem[req_wr_addr_i[k*AW +: 4]] =
                                req_wr_data_i[k*VW +: VW];
                    tb_last = 0;
                    grant_log.push_back(1'b0);
                end else if (ld_valid_i && ld_ready_o) begin
                    ref_mem[ld_addr_i[3:0]] = ld_data_i;
                    tb_last = 1;
                    grant_log.push_back(1'b1);
                end
            end
        end
    end

    task automatic send_req(input logic [1:0] re, input logic [AW-1:0] ra1,
                            input logic [AW-1:0] ra0, input logic [1:0] we,
                            input logic [AW-1:0] wa1, input logic [AW-1:0] wa0,
                            input logic [VW-1:0] wd1, input logic [VW-1:0] wd0);
        bit ok = 0;
        req_rd_en_i   = re;
        req_rd_addr_i = {ra1, ra0};
        req_wr_en_i   = we;
        req_wr_addr_i = {wa1, wa0};
        req_wr_data_i = {wd1, wd0};
        req_valid_i   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL req_timeout: req_ready_o low, wanted high within 200 cycles");
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic send_ld(input logic [AW-1:0] a, input logic [VW-1:0] d);
        bit ok = 0;
        ld_addr_i  = a;
        ld_data_i  = d;
        ld_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ld_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL ld_timeout: ld_ready_o low, wanted high within 200 cycles");
        end
        @(posedge clk);
        #1 ld_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_o && exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL drain_timeout: busy=%b pending=%0d, wanted idle",
                     busy_o, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req();
        send_req(2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                 VW'({$urandom(), $urandom()}), VW'({$urandom(), $urandom()}));
    endtask

    bit stim_done;
    int cyc;

    initial begin
        req_valid_i = 1'b1;
        req_rd_en_i = 2'b11;
        req_rd_addr_i = {30'd2, 30'd1};
        req_wr_en_i = 2'b00;
        req_wr_addr_i = '0;
        req_wr_data_i = '0;
        ld_valid_i = 1'b1;
        ld_addr_i = 30'd1;
        ld_data_i = 63'h77;
        rsp_ready_i = 1'b1;
        clr_mem = 1'b1;
        l3_req_valid = 1'b0;
        l3_rd_en = 2'b00;
        l3_rd_addr = '0;
        stim_done = 0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_ld_ready", ld_ready_o, 0);
        check("rst_mem_rd_en", mem_rd_en_o, 0);
        check("rst_mem_wr_en", mem_wr_en_o, 0);
        check("rst_mem_rd_addr", mem_rd_addr_o, 0);
        check("rst_mem_wr_addr", mem_wr_addr_o, 0);
        check("rst_mem_wr_data", mem_wr_data_o, 0);
        check("rst_rsp", {rsp_mask_o, rsp_data_o}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clr_mem = 1'b0;

        // Both sides held valid: reducer, loader, reducer.
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        ld_valid_i = 1'b0;
        if (grant_log.size() >= 3) begin
            check("grant0", grant_log[0], 0);
            check("grant1", grant_log[1], 1);
            check("grant2", grant_log[2], 0);
        end else begin
            n_chk++;
            $display("FAIL grant_count: got %0d grants, wanted at least 3",
                     grant_log.size());
        end
        wait_drain();

        // Reset in the middle of the write cycle.
        send_req(2'b00, 0, 0, 2'b11, 30'd7, 30'd6, 63'h70, 63'h60);
        @(posedge clk);
        #1 check("pre_rst_wr_en", mem_wr_en_o, 2'b11);
        #1 rst = 1'b1;
        #1 check("rst_mid", {mem_wr_en_o, rsp_valid_o, busy_o}, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", {mem_wr_en_o, rsp_valid_o, busy_o}, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clr_mem = 1'b1;
        @(posedge clk);
        #1 clr_mem = 1'b0;

        // Reads see pre-bundle memory even when a write hits the same cell.
        send_ld(30'd5, 63'h111);
        send_ld(30'd9, 63'h222);
        send_req(2'b11, 30'd9, 30'd5, 2'b01, 30'd0, 30'd5, 63'd0, 63'd1);
        check("issue_rd_en", mem_rd_en_o, 2'b11);
        check("issue_rd_addr", mem_rd_addr_o, {30'd9, 30'd5});
        check("issue_wr_en", mem_wr_en_o, 2'b00);
        @(posedge clk);
        #1 check("write_wr_en", mem_wr_en_o, 2'b01);
        check("write_wr_addr", mem_wr_addr_o, {30'd0, 30'd5});
        check("write_wr_data", mem_wr_data_o, {63'd0, 63'd1});
        check("write_rd_en", mem_rd_en_o, 2'b00);
        wait_drain();

        // Equal-address write pair: only port 1 drives.
        send_req(2'b00, 0, 0, 2'b11, 30'd3, 30'd3, 63'hBB, 63'hAA);
        @(posedge clk);
        #1 check("same_wr_en", mem_wr_en_o, 2'b10);
        check("same_wr_addr", mem_wr_addr_o, {30'd3, 30'd0});
        check("same_wr_data", mem_wr_data_o, {63'hBB, 63'd0});
        wait_drain();
        send_req(2'b11, 30'd5, 30'd3, 2'b00, 0, 0, 0, 0);
        wait_drain();

        // Response back-pressure for five cycles with a bundle waiting.
        rsp_ready_i = 1'b0;
        send_req(2'b01, 30'd0, 30'd9, 2'b00, 0, 0, 0, 0);
        cyc = 0;
        while (!rsp_valid_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        fork
            send_req(2'b10, 30'd3, 30'd0, 2'b01, 0, 30'd9, 0, 63'h999);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", rsp_valid_o, 1);
                    check("stall_req_ready", req_ready_o, 0);
                end
                @(posedge clk);
                #1 rsp_ready_i = 1'b1;
            end
        join
        wait_drain();

        // Randomised traffic from both masters.
        fork
            begin
                fork
                    for (int n = 0; n < 60; n++) begin
                        repeat ($urandom_range(0, 3)) @(posedge clk);
                        #1 rand_req();
                    end
                    for (int n = 0; n < 40; n++) begin
                        repeat ($urandom_range(0, 5)) @(posedge clk);
                        #1 send_ld(AW'($urandom_range(0, 15)),
                                   VW'({$urandom(), $urandom()}));
                    end
                join
                stim_done = 1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 rsp_ready_i = ($urandom_range(0, 3) != 0);
                end
                rsp_ready_i = 1'b1;
            end
        join
        wait_drain();

        // RD_LAT=3 instance captures only on the third cycle after ISSUE.
        l3_rd_en = 2'b11;
        l3_rd_addr = {30'd4, 30'd8};
        l3_req_valid = 1'b1;
        cyc = 0;
        while (!l3_req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 l3_req_valid = 1'b0;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (l3_rsp_valid) break;
        end
        check("l3_latency", cyc, 5);
        check("l3_rsp", {l3_rsp_mask, l3_rsp_data},
              {2'b11, 63'hDEAD, 63'hDEAD});
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
